// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares one data memory between the CPU load/store path and a host port
// (test / program loading). One access is granted per cycle by round-robin,
// with an optional host lock that is limited by a starvation counter.
// Read data is returned through a registered response one cycle after grant.
//
// Optional feature: define DMEM_ARB_BOUNDS_EN to enable the address bounds
// check (out-of-range accesses are granted but their memory enables are
// suppressed, reads return 0, and oob_err becomes sticky until start).
//
// Ports:
//   clk, start                      clock, synchronous active-high reset
//   cpu_ld, cpu_st, cpu_addr,       CPU request (ld/st mutually exclusive)
//   cpu_wdata
//   cpu_stall                       CPU request present but not granted
//   cpu_rdata, cpu_rvalid           registered CPU load response
//   host_req, host_we, host_lock,   host request, held until host_gnt
//   host_addr, host_wdata
//   host_gnt                        host request accepted this cycle
//   host_rdata, host_rvalid         registered host read response
//   mem_addr, mem_loadEn,           drive to data_memory
//   mem_storEn, mem_storData
//   mem_loadData                    combinational read data from data_memory
//   oob_err                         sticky out-of-bounds flag
module dmem_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int MEM_SIZE = 64,
  parameter int LOCK_MAX = 8
) (
  input  logic          clk,
  input  logic          start,
  input  logic          cpu_ld,
  input  logic          cpu_st,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_stall,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_rvalid,
  input  logic          host_req,
  input  logic          host_we,
  input  logic          host_lock,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic [DW-1:0] host_rdata,
  output logic          host_rvalid,
  output logic [AW-1:0] mem_addr,
  output logic          mem_loadEn,
  output logic          mem_storEn,
  output logic [DW-1:0] mem_storData,
  input  logic [DW-1:0] mem_loadData,
  output logic          oob_err
);

  localparam int CW = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] LOCK_LIMIT = CW'(LOCK_MAX);

  // Arbitration state
  logic          r_last_win;     // 0 = CPU won last grant, 1 = host
  logic          r_lock_active;
  logic [CW-1:0] r_lock_cnt;

  // Response registers
  logic          r_cpu_rvalid;
  logic [DW-1:0] r_cpu_rdata;
  logic          r_host_rvalid;
  logic [DW-1:0] r_host_rdata;

  // Combinational arbitration
  logic          w_cpu_req;
  logic          w_host_req;
  logic          w_lock_hold;
  logic          w_cpu_win;
  logic          w_host_win;
  logic          w_grant;
  logic          w_rd;
  logic          w_wr;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;
  logic          w_oob;
  logic          w_lock_clr;

  // Requests are masked while start is high so the whole grant path idles.
  assign w_cpu_req  = (cpu_ld | cpu_st) & ~start;
  assign w_host_req = host_req & ~start;

  // Lock override only while the starvation counter has headroom; once it
  // saturates, normal round-robin hands the next contended cycle to the CPU
  // (the host was the last winner).
  assign w_lock_hold = r_lock_active & (r_lock_cnt < LOCK_LIMIT);

  always_comb begin
    w_cpu_win  = 1'b0;
    w_host_win = 1'b0;
    if (w_cpu_req && w_host_req) begin
      if (w_lock_hold || !r_last_win) begin
        w_host_win = 1'b1;
      end else begin
        w_cpu_win = 1'b1;
      end
    end else if (w_cpu_req) begin
      w_cpu_win = 1'b1;
    end else if (w_host_req) begin
      w_host_win = 1'b1;
    end
  end

  assign w_grant = w_cpu_win | w_host_win;

  // Winner's operands; everything is 0 with no winner.
  always_comb begin
    w_rd    = 1'b0;
    w_wr    = 1'b0;
    w_addr  = '0;
    w_wdata = '0;
    if (w_cpu_win) begin
      w_rd    = cpu_ld;
      w_wr    = cpu_st;
      w_addr  = cpu_addr;
      w_wdata = cpu_wdata;
    end else if (w_host_win) begin
      w_rd    = ~host_we;
      w_wr    = host_we;
      w_addr  = host_addr;
      w_wdata = host_wdata;
    end
  end

`ifdef DMEM_ARB_BOUNDS_EN
  localparam logic [AW:0] MEM_LIMIT = (AW + 1)'(MEM_SIZE);
  logic r_oob_err;
  // Extra top bit keeps the compare valid when MEM_SIZE == 2**AW.
  assign w_oob   = w_grant & ({1'b0, w_addr} >= MEM_LIMIT);
  assign oob_err = r_oob_err;

  always_ff @(posedge clk) begin
    if (start) begin
      r_oob_err <= 1'b0;
    end else if (w_oob) begin
      r_oob_err <= 1'b1;
    end
  end
`else
  assign w_oob   = 1'b0;
  assign oob_err = 1'b0;
`endif

  assign mem_addr     = w_addr;
  assign mem_storData = w_wdata;
  assign mem_loadEn   = w_rd & ~w_oob;
  assign mem_storEn   = w_wr & ~w_oob;

  assign cpu_stall = w_cpu_req & ~w_cpu_win;
  assign host_gnt  = w_host_req & w_host_win;

  // The lock drops as soon as the host lets go of req or lock, or the CPU
  // gets through; the counter is tied to the same condition.
  assign w_lock_clr = ~host_req | ~host_lock | w_cpu_win;

  always_ff @(posedge clk) begin
    if (start) begin
      r_last_win    <= 1'b1;
      r_lock_active <= 1'b0;
      r_lock_cnt    <= '0;
    end else begin
      if (w_grant) begin
        r_last_win <= w_host_win;
      end
      if (w_lock_clr) begin
        r_lock_active <= 1'b0;
        r_lock_cnt    <= '0;
      end else begin
        if (w_host_win) begin
          r_lock_active <= 1'b1;
        end
        // Only locked grants that actually keep the CPU waiting count.
        if (w_host_win && w_cpu_req && (r_lock_cnt < LOCK_LIMIT)) begin
          r_lock_cnt <= r_lock_cnt + CW'(1);
        end
      end
    end
  end

  // Read responses; out-of-range reads (bounds build) return 0.
  always_ff @(posedge clk) begin
    if (start) begin
      r_cpu_rvalid  <= 1'b0;
      r_cpu_rdata   <= '0;
      r_host_rvalid <= 1'b0;
      r_host_rdata  <= '0;
    end else begin
      r_cpu_rvalid  <= w_cpu_win & cpu_ld;
      r_host_rvalid <= w_host_win & ~host_we;
      if (w_cpu_win && cpu_ld) begin
        r_cpu_rdata <= w_oob ? '0 : mem_loadData;
      end
      if (w_host_win && !host_we) begin
        r_host_rdata <= w_oob ? '0 : mem_loadData;
      end
    end
  end

  // Masked by start so a response in flight never shows while reset is held.
  assign cpu_rvalid  = r_cpu_rvalid & ~start;
  assign host_rvalid = r_host_rvalid & ~start;
  assign cpu_rdata   = r_cpu_rdata;
  assign host_rdata  = r_host_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter with a simple data_memory model.
module tb_dmem_arbiter;

  localparam int AW = 8;
  localparam int DW = 8;

`ifdef DMEM_ARB_BOUNDS_EN
  localparam logic BOUNDS = 1'b1;
`else
  localparam logic BOUNDS = 1'b0;
`endif

  logic          clk;
  logic          start;
  logic          cpu_ld, cpu_st;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_stall;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_rvalid;
  logic          host_req, host_we, host_lock;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_gnt;
  logic [DW-1:0] host_rdata;
  logic          host_rvalid;
  logic [AW-1:0] mem_addr;
  logic          mem_loadEn, mem_storEn;
  logic [DW-1:0] mem_storData;
  logic [DW-1:0] mem_loadData;
  logic          oob_err;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem [64];

  dmem_arbiter #(.AW(AW), .DW(DW), .MEM_SIZE(64), .LOCK_MAX(8)) dut (
    .clk(clk), .start(start),
    .cpu_ld(cpu_ld), .cpu_st(cpu_st), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .host_req(host_req), .host_we(host_we), .host_lock(host_lock),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_gnt(host_gnt),
    .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .mem_addr(mem_addr), .mem_loadEn(mem_loadEn), .mem_storEn(mem_storEn),
    .mem_storData(mem_storData), .mem_loadData(mem_loadData), .oob_err(oob_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // data_memory model: combinational read, write on the rising edge.
  assign mem_loadData = (mem_addr < 8'd64) ? mem[mem_addr[5:0]] : '0;
  always @(posedge clk) begin
    if (mem_storEn && mem_addr < 8'd64) mem[mem_addr[5:0]] <= mem_storData;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_ld = 0; cpu_st = 0; cpu_addr = '0; cpu_wdata = '0;
    host_req = 0; host_we = 0; host_lock = 0; host_addr = '0; host_wdata = '0;
  endtask

  task automatic do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[5]  = 8'h3C;
    mem[2]  = 8'h11;
    mem[10] = 8'h77;
    idle_inputs();
    start = 1'b1;
    tick();
    tick();

    // Reset state, with requests present while start is held
    cpu_ld = 1; cpu_addr = 8'd5; host_req = 1; host_addr = 8'd10;
    #1;
    chk("rst_cpu_rvalid", cpu_rvalid, 0);
    chk("rst_host_rvalid", host_rvalid, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_host_rdata", host_rdata, 0);
    chk("rst_oob", oob_err, 0);
    chk("rst_stall", cpu_stall, 0);
    chk("rst_host_gnt", host_gnt, 0);
    chk("rst_loadEn", mem_loadEn, 0);
    chk("rst_mem_addr", mem_addr, 0);
    idle_inputs();
    start = 1'b0;
    tick();

    // CPU only load of addr 5
    cpu_ld = 1; cpu_addr = 8'd5;
    #1;
    chk("cpu_only_stall", cpu_stall, 0);
    chk("cpu_only_loadEn", mem_loadEn, 1);
    chk("cpu_only_addr", mem_addr, 5);
    tick();
    cpu_ld = 0;
    #1;
    chk("cpu_only_rvalid", cpu_rvalid, 1);
    chk("cpu_only_rdata", cpu_rdata, 8'h3C);
    tick();
    chk("cpu_only_rvalid_drop", cpu_rvalid, 0);

    // Contention right after reset: CPU store wins, host read follows
    do_reset();
    cpu_st = 1; cpu_addr = 8'd2; cpu_wdata = 8'hAA;
    host_req = 1; host_we = 0; host_addr = 8'd2;
    #1;
    chk("cont_stall", cpu_stall, 0);
    chk("cont_host_gnt0", host_gnt, 0);
    chk("cont_storEn", mem_storEn, 1);
    chk("cont_loadEn0", mem_loadEn, 0);
    chk("cont_addr", mem_addr, 2);
    chk("cont_storData", mem_storData, 8'hAA);
    tick();
    cpu_st = 0;
    #1;
    chk("cont_host_gnt1", host_gnt, 1);
    chk("cont_loadEn1", mem_loadEn, 1);
    chk("cont_store_no_rvalid", cpu_rvalid, 0);
    tick();
    host_req = 0;
    #1;
    chk("cont_host_rvalid", host_rvalid, 1);
    chk("cont_host_rdata", host_rdata, 8'hAA);

    // Round-robin for 4 cycles (host won last)
    cpu_ld = 1; cpu_addr = 8'd5;
    host_req = 1; host_we = 0; host_addr = 8'd10;
    #1;
    chk("rr0_stall", cpu_stall, 0);
    chk("rr0_gnt", host_gnt, 0);
    tick();
    chk("rr1_stall", cpu_stall, 1);
    chk("rr1_gnt", host_gnt, 1);
    chk("rr1_cpu_rvalid", cpu_rvalid, 1);
    chk("rr1_cpu_rdata", cpu_rdata, 8'h3C);
    tick();
    chk("rr2_stall", cpu_stall, 0);
    chk("rr2_gnt", host_gnt, 0);
    chk("rr2_host_rvalid", host_rvalid, 1);
    chk("rr2_host_rdata", host_rdata, 8'h77);
    tick();
    chk("rr3_stall", cpu_stall, 1);
    chk("rr3_gnt", host_gnt, 1);
    tick();
    idle_inputs();
    #1;
    tick();

    // Lock starvation: CPU wins a grant first so the host wins the next contention
    cpu_ld = 1; cpu_addr = 8'd5;
    tick();
    host_req = 1; host_lock = 1; host_we = 1; host_addr = 8'd20; host_wdata = 8'h5A;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("lock%0d_gnt", k), host_gnt, 1);
      chk($sformatf("lock%0d_stall", k), cpu_stall, 1);
      chk($sformatf("lock%0d_cnt", k), 32'(dut.r_lock_cnt), k);
      tick();
    end
    #1;
    chk("lock8_stall", cpu_stall, 0);
    chk("lock8_gnt", host_gnt, 0);
    chk("lock8_cnt", 32'(dut.r_lock_cnt), 8);
    tick();
    chk("lock_cnt_cleared", 32'(dut.r_lock_cnt), 0);
    chk("lock_host_write", mem[20], 8'h5A);
    idle_inputs();
    tick();

    // Reset while a host read response is in flight
    host_req = 1; host_we = 0; host_addr = 8'd10;
    #1;
    chk("rstmid_gnt", host_gnt, 1);
    tick();
    host_req = 0;
    start = 1;
    tick();
    chk("rstmid_host_rvalid", host_rvalid, 0);
    chk("rstmid_host_rdata", host_rdata, 0);
    chk("rstmid_cpu_rdata", cpu_rdata, 0);
    chk("rstmid_cpu_rvalid", cpu_rvalid, 0);
    chk("rstmid_storEn", mem_storEn, 0);
    chk("rstmid_storData", mem_storData, 0);
    chk("rstmid_lock_cnt", 32'(dut.r_lock_cnt), 0);
    start = 0;
    tick();

    // Out-of-range store to addr 70
    cpu_st = 1; cpu_addr = 8'd70; cpu_wdata = 8'h55;
    #1;
    chk("oob_st_storEn", mem_storEn, !BOUNDS);
    chk("oob_st_addr", mem_addr, 70);
    tick();
    cpu_st = 0;
    #1;
    chk("oob_err_set", oob_err, BOUNDS);
    tick();
    chk("oob_err_sticky", oob_err, BOUNDS);
    cpu_ld = 1; cpu_addr = 8'd70;
    #1;
    chk("oob_ld_loadEn", mem_loadEn, !BOUNDS);
    tick();
    cpu_addr = 8'd5;
    #1;
    chk("oob_ld_rvalid", cpu_rvalid, 1);
    chk("oob_ld_rdata", cpu_rdata, 0);
    chk("valid_ld_loadEn", mem_loadEn, 1);
    tick();
    cpu_ld = 0;
    #1;
    chk("valid_ld_rvalid", cpu_rvalid, 1);
    chk("valid_ld_rdata", cpu_rdata, 8'h3C);
    chk("oob_err_still", oob_err, BOUNDS);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single data memory between the CPU load/store path and a host port used for test and program loading. It grants one memory access per cycle using round-robin priority, with an optional host lock that is bounded by a starvation counter. Read data is returned through a registered response one cycle after the grant. It sits between the control logic/register file (address, load/store enables, store data) and `data_memory`.

## Interface
Parameters:
- `AW`, 8, address width (CPU addresses come from `ra`/`rb`).
- `DW`, 8, data width.
- `MEM_SIZE`, 64, number of implemented memory words; used by the bounds check.
- `LOCK_MAX`, 8, maximum consecutive host-locked grants while the CPU is waiting.

Ports (one clock; reset is synchronous, active-high):
- `clk` in 1: clock; all state updates on the rising edge.
- `start` in 1: synchronous active-high reset.
- `cpu_ld` in 1: CPU load request.
- `cpu_st` in 1: CPU store request. `cpu_ld` and `cpu_st` are never both 1.
- `cpu_addr` in AW: CPU address.
- `cpu_wdata` in DW: CPU store data.
- `cpu_stall` out 1: CPU request present but not granted this cycle.
- `cpu_rdata` out DW: registered load data.
- `cpu_rvalid` out 1: `cpu_rdata` is valid this cycle.
- `host_req` in 1: host request, held until granted.
- `host_we` in 1: host write (1) or read (0).
- `host_lock` in 1: host asks to keep the grant.
- `host_addr` in AW, `host_wdata` in DW: host address and write data.
- `host_gnt` out 1: host request accepted this cycle.
- `host_rdata` out DW, `host_rvalid` out 1: registered host read response.
- `mem_addr` out AW, `mem_loadEn` out 1, `mem_storEn` out 1, `mem_storData` out DW: drive `data_memory`.
- `mem_loadData` in DW: combinational read data from `data_memory`.
- `oob_err` out 1: sticky out-of-bounds flag (see Configuration).

## Operation
- Requests: `cpu_req = cpu_ld | cpu_st`. The host request is `host_req`.
- Arbitration is combinational within the cycle.
  - One requester only: that requester wins.
  - Both requesting: the requester that did not win last (`last_win` register, 0 = CPU, 1 = host) wins.
  - Lock override: if `lock_active` is set and `lock_cnt < LOCK_MAX`, the host wins regardless of `last_win`.
- Lock tracking:
  - `lock_active` sets on a host grant with `host_lock` = 1.
  - It clears on any cycle with `host_req` = 0, `host_lock` = 0, or a CPU grant.
- Lock counter:
  - `lock_cnt` increments on each locked host grant while `cpu_req` = 1, saturating at `LOCK_MAX`.
  - It clears on any CPU grant or when `lock_active` clears.
  - At `LOCK_MAX`, the CPU is forced to win the next cycle it requests.
- Memory drive:
  - The winner's address goes to `mem_addr`.
  - `mem_loadEn` is the winner's read; `mem_storEn` is the winner's write; `mem_storData` is the winner's write data.
  - With no winner, both enables are 0 and `mem_addr`/`mem_storData` are 0.
- `cpu_stall = cpu_req & ~cpu_win`.
- `host_gnt = host_req & host_win`.
- Read response: on a granted read, `mem_loadData` is captured into the winner's `*_rdata` register, and the matching `*_rvalid` pulses the next cycle. `*_rdata` holds its value until the next granted read.
- A store produces no rvalid.
- `last_win` updates only on a cycle with a grant.

## Timing
- Reset (`start` = 1 at the edge): all outputs and state are 0.
  - This includes `cpu_rvalid`, `host_rvalid`, `cpu_rdata`, `host_rdata`, `oob_err`, `lock_cnt` and `lock_active`.
  - `last_win` resets to 1, so the CPU wins the first contention.
  - While `start` is high, the combinational grant logic is forced idle: no memory enables, `cpu_stall` = 0, `host_gnt` = 0.
  - A read granted in the cycle before reset asserts produces no rvalid after reset.
- Grant to memory: 0 cycles, combinational in the request cycle.
- Read latency: rvalid is asserted exactly 1 cycle after the grant.
- Back-to-back grants are allowed every cycle. Throughput is one access per cycle total.
- Host handshake: `host_req`, `host_we`, `host_addr` and `host_wdata` stay stable until the cycle `host_gnt` = 1. The request may be dropped or changed the cycle after.
- CPU handshake: the CPU holds its request and operands while `cpu_stall` = 1.
- Simultaneous CPU store and host read of the same address: the winner goes first. The loser sees the updated memory on its later grant.

## Configuration
- `DMEM_ARB_BOUNDS_EN` defined:
  - A granted access with `addr >= MEM_SIZE` is still granted, but `mem_loadEn`/`mem_storEn` are suppressed.
  - A read returns rdata = 0 with rvalid asserted as normal.
  - `oob_err` sets and stays set until `start`.
- Not defined: no check is made, addresses pass through unmodified, and `oob_err` is tied to 0.

## Test plan
- CPU only: after reset, `cpu_ld` with addr 5, where mem[5] = 8'h3C. Required: `cpu_stall` = 0, `mem_loadEn` = 1, `mem_addr` = 5; next cycle `cpu_rvalid` = 1, `cpu_rdata` = 8'h3C.
- Contention: CPU store (addr 2, data 8'hAA) and host read (addr 2) in the same cycle, first after reset. Required: CPU wins and the store is issued; the host is granted the next cycle; `host_rdata` = 8'hAA with `host_rvalid` the cycle after that.
- Round-robin: both request continuously for 4 cycles. Required grant order CPU, host, CPU, host; `cpu_stall` = 0, 1, 0, 1.
- Lock starvation, `LOCK_MAX` = 8: host holds `host_req` = `host_lock` = 1 with the CPU requesting. Required: the host wins 8 consecutive grants, the CPU wins on the 9th cycle, then `lock_cnt` = 0.
- Reset mid-read: a host read is granted, then `start` = 1 on the next edge. Required: `host_rvalid` = 0 and all outputs 0 after reset.
- With `DMEM_ARB_BOUNDS_EN`: CPU store to addr 70. Required: `mem_storEn` = 0, `oob_err` = 1 and sticky; a later valid access still works.
